// File: rtl/lmc1992_pkg.sv
// LMC1992 constants: command encoding, register limits/reset values, gain table.
// Latency: n/a (definitions only); no backpressure.
package lmc1992_pkg;

  localparam logic [2:0] FN_MIX    = 3'b000;
  localparam logic [2:0] FN_BASS   = 3'b001;
  localparam logic [2:0] FN_TREBLE = 3'b010;
  localparam logic [2:0] FN_MASTER = 3'b011;
  localparam logic [2:0] FN_RIGHT  = 3'b100;
  localparam logic [2:0] FN_LEFT   = 3'b101;
  localparam logic [1:0] DEV_ADDR  = 2'b10;

  localparam int MASTER_MAX = 40;
  localparam int CH_MAX     = 20;
  localparam int TONE_MAX   = 12;
  localparam int IDX_MUTE   = 40;

  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_CH     = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIX    = 2'b01;

  // round(32767 * 10^(-i/10)): 2 dB per step, last entry forced to mute
  localparam logic [15:0] GAIN_LUT [0:40] = '{
    16'd32767, 16'd26028, 16'd20675, 16'd16422, 16'd13045,
    16'd10362, 16'd8231,  16'd6538,  16'd5193,  16'd4125,
    16'd3277,  16'd2603,  16'd2067,  16'd1642,  16'd1304,
    16'd1036,  16'd823,   16'd654,   16'd519,   16'd413,
    16'd328,   16'd260,   16'd207,   16'd164,   16'd130,
    16'd104,   16'd82,    16'd65,    16'd52,    16'd41,
    16'd33,    16'd26,    16'd21,    16'd16,    16'd13,
    16'd10,    16'd8,     16'd7,     16'd5,     16'd4,
    16'd0
  };

  function automatic logic [5:0] atten_idx(input logic [5:0] master, input logic [4:0] ch);
    logic [6:0] sum;
    sum = (7'(MASTER_MAX) - {1'b0, master}) + (7'(CH_MAX) - {2'b00, ch});
    return (sum > 7'(IDX_MUTE)) ? 6'(IDX_MUTE) : sum[5:0];
  endfunction

endpackage

// File: rtl/lmc_gain_rom.sv
// 41x16 gain ROM, registered read; out-of-range index reads as mute.
// Latency: 1 cycle from en to gain; no backpressure.
module lmc_gain_rom
  import lmc1992_pkg::*;
(
  input  logic        clk32,
  input  logic        reset,
  input  logic        en,
  input  logic [5:0]  idx,
  output logic [15:0] gain
);

  always_ff @(posedge clk32) begin
    if (reset) begin
      gain <= '0;
    end else if (en) begin
      gain <= (idx > 6'(IDX_MUTE)) ? 16'd0 : GAIN_LUT[idx];
    end
  end

endmodule

// File: rtl/lmc1992_mw_rx.sv
// Microwire command receiver for the LMC1992 registers plus per-channel sample attenuation.
// Latency: registers update 1 cycle after mw_done, samples out 2 cycles after sample_en; no backpressure.
module lmc1992_mw_rx
  import lmc1992_pkg::*;
#(
  parameter int GAIN_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic             clk32,
  input  logic             reset,
  input  logic             mw_stb,
  input  logic             mw_clk,
  input  logic             mw_data,
  input  logic             mw_done,
  input  logic             sample_en,
  input  logic [7:0]       sample_l,
  input  logic [7:0]       sample_r,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r,
  output logic [5:0]       master_vol,
  output logic [4:0]       left_vol,
  output logic [4:0]       right_vol,
  output logic [3:0]       bass,
  output logic [3:0]       treble,
  output logic [1:0]       mix,
  output logic             cmd_ok,
  output logic             cmd_err
);

  logic [10:0] sr, sr_nxt;
  logic [3:0]  bcnt, bcnt_nxt;
  logic [2:0]  fn;
  logic [5:0]  d;
  logic        frame_ok;

  // A capture on the mw_done cycle is folded in before evaluation.
  always_comb begin
    sr_nxt   = sr;
    bcnt_nxt = bcnt;
    if (mw_stb && mw_clk) begin
      sr_nxt = {sr[9:0], mw_data};
      if (bcnt != 4'd15) bcnt_nxt = bcnt + 4'd1;
    end
  end

  assign fn       = sr_nxt[8:6];
  assign d        = sr_nxt[5:0];
  assign frame_ok = (bcnt_nxt == 4'd11) && (sr_nxt[10:9] == DEV_ADDR) && (fn[2:1] != 2'b11);

  always_ff @(posedge clk32) begin
    if (reset) begin
      sr         <= '0;
      bcnt       <= '0;
      cmd_ok     <= 1'b0;
      cmd_err    <= 1'b0;
      master_vol <= RST_MASTER;
      left_vol   <= RST_CH;
      right_vol  <= RST_CH;
      bass       <= RST_TONE;
      treble     <= RST_TONE;
      mix        <= RST_MIX;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      if (mw_done) begin
        sr   <= '0;
        bcnt <= '0;
        if (frame_ok) begin
          cmd_ok <= 1'b1;
          case (fn)
            FN_MIX:    mix        <= d[1:0];
            FN_BASS:   bass       <= (d[3:0] > 4'(TONE_MAX))   ? 4'(TONE_MAX)   : d[3:0];
            FN_TREBLE: treble     <= (d[3:0] > 4'(TONE_MAX))   ? 4'(TONE_MAX)   : d[3:0];
            FN_MASTER: master_vol <= (d > 6'(MASTER_MAX))      ? 6'(MASTER_MAX) : d;
            FN_RIGHT:  right_vol  <= (d[4:0] > 5'(CH_MAX))     ? 5'(CH_MAX)     : d[4:0];
            FN_LEFT:   left_vol   <= (d[4:0] > 5'(CH_MAX))     ? 5'(CH_MAX)     : d[4:0];
            default:   ;
          endcase
        end else begin
          cmd_err <= 1'b1;
        end
      end else begin
        sr   <= sr_nxt;
        bcnt <= bcnt_nxt;
      end
    end
  end

  logic [GAIN_W-1:0] gain_l, gain_r;
  logic [7:0]        s1_l, s1_r;
  logic              s1_vld;

  lmc_gain_rom u_rom_l (
    .clk32 (clk32),
    .reset (reset),
    .en    (sample_en),
    .idx   (atten_idx(master_vol, left_vol)),
    .gain  (gain_l)
  );

  lmc_gain_rom u_rom_r (
    .clk32 (clk32),
    .reset (reset),
    .en    (sample_en),
    .idx   (atten_idx(master_vol, right_vol)),
    .gain  (gain_r)
  );

  logic signed [GAIN_W+8:0] prod_l, prod_r;
  assign prod_l = $signed(s1_l) * $signed({1'b0, gain_l});
  assign prod_r = $signed(s1_r) * $signed({1'b0, gain_r});

  logic unused_prod;
  assign unused_prod = ^{prod_l[GAIN_W+8:OUT_W+7], prod_l[6:0],
                         prod_r[GAIN_W+8:OUT_W+7], prod_r[6:0]};

  always_ff @(posedge clk32) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_l      <= '0;
      s1_r      <= '0;
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
    end else begin
      s1_vld    <= sample_en;
      out_valid <= s1_vld;
      if (sample_en) begin
        s1_l <= sample_l;
        s1_r <= sample_r;
      end
      if (s1_vld) begin
        out_l <= prod_l[OUT_W+6:7];
        out_r <= prod_r[OUT_W+6:7];
      end
    end
  end

endmodule

// File: tb/tb_lmc1992_mw_rx.sv
// Directed bench for lmc1992_mw_rx: microwire command sequences and a sample scoreboard.
module tb_lmc1992_mw_rx;

  logic        clk32 = 1'b0;
  logic        reset = 1'b1;
  logic        mw_stb = 1'b0, mw_clk = 1'b0, mw_data = 1'b0, mw_done = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  sample_l = '0, sample_r = '0;
  logic        out_valid;
  logic [15:0] out_l, out_r;
  logic [5:0]  master_vol;
  logic [4:0]  left_vol, right_vol;
  logic [3:0]  bass, treble;
  logic [1:0]  mix;
  logic        cmd_ok, cmd_err;

  lmc1992_mw_rx dut (
    .clk32(clk32), .reset(reset),
    .mw_stb(mw_stb), .mw_clk(mw_clk), .mw_data(mw_data), .mw_done(mw_done),
    .sample_en(sample_en), .sample_l(sample_l), .sample_r(sample_r),
    .out_valid(out_valid), .out_l(out_l), .out_r(out_r),
    .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
    .bass(bass), .treble(treble), .mix(mix),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err)
  );

  always #5 clk32 = ~clk32;

  int total = 0;
  int bad   = 0;
  int n_pushed = 0;
  int n_seen   = 0;
  int exp_l_q[$];
  int exp_r_q[$];

  int m_master, m_left, m_right, m_bass, m_treble, m_mix;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  function automatic int gain_of(input int i);
    if (i >= 40) return 0;
    return $rtoi(32767.0 * (10.0 ** (-i / 10.0)) + 0.5);
  endfunction

  function automatic int exp_out(input int s, input int chv);
    int idx;
    idx = (40 - m_master) + (20 - chv);
    if (idx > 40) idx = 40;
    return (s * gain_of(idx)) >>> 7;
  endfunction

  task automatic model_reset();
    m_master = 40; m_left = 20; m_right = 20;
    m_bass = 6; m_treble = 6; m_mix = 1;
  endtask

  task automatic model_apply(input int fn, input int d);
    case (fn)
      0: m_mix    = d % 4;
      1: m_bass   = ((d % 16) > 12) ? 12 : d % 16;
      2: m_treble = ((d % 16) > 12) ? 12 : d % 16;
      3: m_master = (d > 40) ? 40 : d;
      4: m_right  = ((d % 32) > 20) ? 20 : d % 32;
      5: m_left   = ((d % 32) > 20) ? 20 : d % 32;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".master"}, int'(master_vol), m_master);
    check({tag, ".left"},   int'(left_vol),   m_left);
    check({tag, ".right"},  int'(right_vol),  m_right);
    check({tag, ".bass"},   int'(bass),       m_bass);
    check({tag, ".treble"}, int'(treble),     m_treble);
    check({tag, ".mix"},    int'(mix),        m_mix);
  endtask

  task automatic slot(input bit msk, input bit b, input bit done);
    tick();
    mw_stb = 1'b1; mw_clk = msk; mw_data = b; mw_done = done;
    tick();
    mw_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
  endtask

  task automatic finish_cmd(input string tag, input bit done_sent, input bit exp_ok,
                            input int fn, input int d);
    if (!done_sent) begin
      mw_done = 1'b1;
      tick();
      mw_done = 1'b0;
    end
    check({tag, ".cmd_ok"},  int'(cmd_ok),  int'(exp_ok));
    check({tag, ".cmd_err"}, int'(cmd_err), int'(!exp_ok));
    if (exp_ok) model_apply(fn, d);
    tick();
    check({tag, ".ok_pulse"}, int'(cmd_ok), 0);
  endtask

  task automatic send_bits(input string tag, input logic [15:0] bits, input int n,
                           input bit done_last, input bit exp_ok);
    for (int i = n - 1; i >= 0; i--) slot(1'b1, bits[i], done_last && (i == 0));
    finish_cmd(tag, done_last, exp_ok, int'(bits[8:6]), int'(bits[5:0]));
  endtask

  task automatic send_cmd(input string tag, input int fn, input int d);
    logic [15:0] c;
    c = {5'b0, 2'b10, 3'(fn), 6'(d)};
    send_bits(tag, c, 11, 1'b0, 1'b1);
  endtask

  task automatic push_sample(input int l, input int r);
    sample_en = 1'b1;
    sample_l = 8'(l);
    sample_r = 8'(r);
    exp_l_q.push_back(exp_out(l, m_left));
    exp_r_q.push_back(exp_out(r, m_right));
    n_pushed++;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  always @(negedge clk32) begin
    if (!reset && out_valid) begin
      n_seen++;
      if (exp_l_q.size() > 0 && exp_r_q.size() > 0) begin
        check("out_l", int'($signed(out_l)), exp_l_q.pop_front());
        check("out_r", int'($signed(out_r)), exp_r_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] c;
    logic [15:0] msk;
    int j;

    model_reset();
    repeat (3) tick();
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_l", int'(out_l), 0);
    check("rst.cmd_ok", int'(cmd_ok), 0);
    check_regs("rst");
    reset = 1'b0;
    tick();

    // 1: full scale at 0 dB
    push_sample(127, 127);
    drain();
    check_regs("t1");

    // 2: master to 20 -> -40 dB
    send_bits("t2", 16'b00000_10_011_010100, 11, 1'b0, 1'b1);
    check("t2.master", int'(master_vol), 20);
    push_sample(127, -128);
    drain();

    // 3: master and left at minimum -> mute on both channels
    send_cmd("t3l", 5, 0);
    send_cmd("t3m", 3, 0);
    check_regs("t3");
    push_sample(127, 127);
    push_sample(-128, 50);
    drain();
    send_cmd("t3r1", 3, 40);
    send_cmd("t3r2", 5, 20);

    // 4: malformed transfers
    c = {5'b0, 2'b10, 3'b011, 6'd10};
    send_bits("t4.short", c >> 1, 10, 1'b0, 1'b0);
    send_bits("t4.long", {c[14:0], 1'b1}, 12, 1'b0, 1'b0);
    send_bits("t4.addr", {5'b0, 2'b01, 3'b011, 6'd10}, 11, 1'b0, 1'b0);
    send_bits("t4.fn110", {5'b0, 2'b10, 3'b110, 6'd10}, 11, 1'b0, 1'b0);
    check_regs("t4");

    // 5: masked slots interleaved with the 11 real bits
    c   = {5'b0, 2'b10, 3'b010, 6'd3};
    msk = 16'b1101_1011_0110_1011;
    j   = 10;
    for (int k = 15; k >= 0; k--) begin
      if (msk[k]) begin
        slot(1'b1, c[j], 1'b0);
        j--;
      end else begin
        slot(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    finish_cmd("t5.mask", 1'b0, 1'b1, 2, 3);
    check("t5.treble", int'(treble), 3);
    send_cmd("t5.bass", 1, 15);
    check("t5.bass", int'(bass), 12);

    // 6: reset drops a partial command
    c = {5'b0, 2'b10, 3'b100, 6'd10};
    for (int i = 10; i >= 6; i--) slot(1'b1, c[i], 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check_regs("t6.rst");
    send_cmd("t6.right", 4, 10);
    check("t6.right", int'(right_vol), 10);
    send_bits("t6.same", {5'b0, 2'b10, 3'b000, 6'd2}, 11, 1'b1, 1'b1);
    check("t6.mix", int'(mix), 2);

    // back-to-back samples with mixed volumes
    send_cmd("bb.master", 3, 36);
    send_cmd("bb.left", 5, 17);
    for (int i = 0; i < 8; i++) begin
      sample_en = 1'b1;
      sample_l = 8'($urandom_range(0, 255));
      sample_r = 8'($urandom_range(0, 255));
      exp_l_q.push_back(exp_out(int'($signed(sample_l)), m_left));
      exp_r_q.push_back(exp_out(int'($signed(sample_r)), m_right));
      n_pushed++;
      tick();
    end
    sample_en = 1'b0;
    drain();

    check("outs_seen", n_seen, n_pushed);
    check("queue_left", exp_l_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
